// File: rtl/pixel_sink_framebuffer.sv
// rtl/pixel_sink_framebuffer.sv - drawer pixel sink with write FIFO, 160x120x3 frame memory and coherent read-back
module pixel_sink_framebuffer #(
  parameter int FIFO_DEPTH = 16,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       writeEn,
  output logic       full,
  output logic       overflow,
  output logic [7:0] oob_count,
  input  logic       rd_req,
  input  logic [7:0] rd_x,
  input  logic [6:0] rd_y,
  output logic       rd_busy,
  output logic       rd_valid,
  output logic [2:0] rd_colour,
  output logic       idle
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int ADDR_W    = 15;
  localparam int ENTRY_W   = ADDR_W + 3;
  localparam int MEM_WORDS = SCREEN_W * SCREEN_H;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       X_LIMIT   = 8'(SCREEN_W);
  localparam logic [6:0]       Y_LIMIT   = 7'(SCREEN_H);

  // R_ISSUE is the cycle that owns the memory port for the read; R_DATA
  // turns the registered memory output into rd_colour / rd_valid.
  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WAIT  = 2'd1,
    R_ISSUE = 2'd2,
    R_DATA  = 2'd3
  } rd_state_t;

  // Linear address y*160 + x built from shifts so no multiplier is needed.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [7:0] px, input logic [6:0] py);
    return {1'b0, py, 7'b0} + {3'b0, py, 5'b0} + {7'b0, px};
  endfunction

  // Input filter
  logic               pix_in_range;
  logic               push;
  logic               drop_full;
  logic               drop_oob;
  logic [ADDR_W-1:0]  pix_addr;

  // Write FIFO
  logic [ENTRY_W-1:0] fifo_mem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               fifo_empty;
  logic               pop;
  logic [ENTRY_W-1:0] head_entry;
  logic [ADDR_W-1:0]  head_addr;
  logic [2:0]         head_colour;

  // Read path
  rd_state_t          state;
  rd_state_t          state_next;
  logic               rd_accept;
  logic               rd_slot;
  logic               rd_done;
  logic               rd_in_range;
  logic [ADDR_W-1:0]  rd_pix_addr;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic               rd_oob_q;

  // Frame memory
  logic [2:0]         frame_mem [0:MEM_WORDS-1];
  logic               mem_we;
  logic               mem_re;
  logic [2:0]         mem_q;

  assign pix_in_range = (x < X_LIMIT) && (y < Y_LIMIT);
  assign pix_addr     = pixel_addr(x, y);
  assign push         = writeEn && pix_in_range && !full;
  assign drop_full    = writeEn && pix_in_range && full;
  assign drop_oob     = writeEn && !pix_in_range;

  assign fifo_empty   = (count == '0);
  assign head_entry   = fifo_mem[rd_ptr];
  assign head_addr    = head_entry[ENTRY_W-1:3];
  assign head_colour  = head_entry[2:0];

  // The read only reaches R_ISSUE with the FIFO empty, so holding off the pop
  // in that cycle only delays pixels pushed after the read was committed.
  assign pop          = !fifo_empty && !rd_slot;

  assign rd_in_range  = (rd_x < X_LIMIT) && (rd_y < Y_LIMIT);
  assign rd_pix_addr  = pixel_addr(rd_x, rd_y);
  assign rd_busy      = (state != R_IDLE);

  assign mem_we       = pop;
  assign mem_re       = rd_slot && !rd_oob_q;

  // FIFO occupancy after this edge's push/pop.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  // FIFO entry storage; contents need no reset because the pointers guard them.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {pix_addr, colour};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
    end
  end

  // Single-port synchronous frame memory: at most one of write or read per cycle.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      frame_mem[head_addr] <= head_colour;
    end
    if (mem_re) begin
      mem_q <= frame_mem[rd_addr_q];
    end
  end

  // Read state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= R_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Read next-state and per-state strobes.
  always_comb begin
    state_next = state;
    rd_accept  = 1'b0;
    rd_slot    = 1'b0;
    rd_done    = 1'b0;
    case (state)
      R_IDLE: begin
        if (rd_req) begin
          rd_accept  = 1'b1;
          state_next = R_WAIT;
        end
      end
      R_WAIT: begin
        if (fifo_empty) begin
          state_next = R_ISSUE;
        end
      end
      R_ISSUE: begin
        rd_slot    = 1'b1;
        state_next = R_DATA;
      end
      R_DATA: begin
        rd_done    = 1'b1;
        state_next = R_IDLE;
      end
      default: begin
        state_next = R_IDLE;
      end
    endcase
  end

  // Latch the read coordinates when the request is taken.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q <= '0;
      rd_oob_q  <= 1'b0;
    end else if (rd_accept) begin
      rd_addr_q <= rd_pix_addr;
      rd_oob_q  <= !rd_in_range;
    end
  end

  // Read result: out-of-range reads return 0 with the same timing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid  <= 1'b0;
      rd_colour <= 3'd0;
    end else begin
      rd_valid <= rd_done;
      if (rd_done) begin
        rd_colour <= rd_oob_q ? 3'd0 : mem_q;
      end
    end
  end

  // Registered status flags and the discarded-pixel counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full      <= 1'b0;
      idle      <= 1'b1;
      overflow  <= 1'b0;
      oob_count <= 8'd0;
    end else begin
      full <= (count_next == DEPTH_CNT);
      idle <= (count_next == '0) && (state_next == R_IDLE);
      if (drop_full) begin
        overflow <= 1'b1;
      end
      if (drop_oob && (oob_count != 8'hFF)) begin
        oob_count <= oob_count + 8'd1;
      end
    end
  end

endmodule
